writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the register data width (legal: 32, 64).
REQ-002 Parameter REG_AW, default 5, SHALL set the register address width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL mark a retiring instruction on the input bus.
REQ-006 in_ready  output  1  SHALL indicate the stage accepts an instruction this cycle.
REQ-007 in_we  input  1  SHALL be the instruction's register-write request.
REQ-008 in_rd  input  REG_AW  SHALL be the destination register address.
REQ-009 in_src  input  2  SHALL select the result source: 0=ALU, 1=load, 2=link (PC+4), 3=reserved.
REQ-010 in_funct3  input  3  SHALL encode the load size/sign: 000 LB, 001 LH, 010 LW, 011 LD (XLEN=64 only), 100 LBU, 101 LHU, 110 LWU (XLEN=64 only).
REQ-011 in_alu, in_link  input  XLEN each  SHALL carry the ALU result and link value; in_alu doubles as load address.
REQ-012 mem_rvalid  input  1  SHALL mark mem_rdata valid.
REQ-013 mem_rdata  input  XLEN  SHALL be the aligned memory word containing the load data.
REQ-014 rd_we  output  1  SHALL be the one-cycle register-file write strobe.
REQ-015 rd_addr  output  REG_AW  SHALL be the register-file write address.
REQ-016 rd_data  output  XLEN  SHALL be the register-file write data.
REQ-017 trap  output  1  SHALL pulse one cycle on a misaligned load (present only per REQ-034).

Function
REQ-018 States SHALL be IDLE and WAIT_MEM; in_ready SHALL equal (state==IDLE).
REQ-019 IDLE, in_valid, in_src!=1: SHALL register result, rd_addr<=in_rd, rd_we<=in_we, in the next cycle (latency 1); stay IDLE.
REQ-020 IDLE, in_valid, in_src==1: SHALL latch in_rd, in_we, in_funct3, in_alu low bits; go WAIT_MEM; rd_we<=0.
REQ-021 IDLE, in_valid, in_src==1, mem_rvalid already high in the same cycle: SHALL treat as WAIT_MEM completion immediately (write next cycle, stay IDLE).
REQ-022 WAIT_MEM, mem_rvalid high: SHALL extract byte/half/word/dword at offset in_alu[2:0] (low bits modulo access size per XLEN), sign- or zero-extend per funct3, write next cycle, return IDLE.
REQ-023 WAIT_MEM, mem_rvalid low: SHALL hold state, rd_we=0, in_ready=0 indefinitely.
REQ-024 rd_we SHALL be forced 0 when destination address is 0; rd_addr/rd_data still update.
REQ-025 rd_we SHALL be a single-cycle pulse per accepted instruction; it SHALL be 0 in every cycle with no completion.
REQ-026 in_src==3 SHALL complete like ALU with rd_we forced 0.
REQ-027 Illegal funct3 for the configured XLEN (011, 110 at XLEN=32; 111 always) SHALL write zero data.
REQ-028 mem_rvalid in IDLE without a pending load SHALL be ignored.

Reset
REQ-029 rst high SHALL force state=IDLE, rd_we=0, rd_addr=0, rd_data=0, trap=0 on the next edge.
REQ-030 rst during WAIT_MEM SHALL abandon the pending load with no write, even if mem_rvalid is high in that cycle.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-033 Macro WB_MISALIGN_CHECK_EN SHALL compile misaligned-load detection in or out.
REQ-034 With WB_MISALIGN_CHECK_EN defined: a load whose address is not size-aligned SHALL skip WAIT_MEM, pulse trap one cycle later, force rd_we=0, and stay IDLE.
REQ-035 Without WB_MISALIGN_CHECK_EN: trap SHALL be tied 0 and misaligned loads SHALL use the low offset bits as in REQ-022.

Verification
REQ-036 ALU: in_valid=1, in_src=0, in_rd=5, in_alu=0x1234, in_we=1 -> next cycle rd_we=1, rd_addr=5, rd_data=0x00001234.
REQ-037 LB sign: in_src=1, funct3=000, in_alu=0x3, mem_rvalid 3 cycles later, mem_rdata=0x80FFFFFF -> in_ready=0 for 3 cycles, then rd_data=0xFFFFFF80, rd_we=1 once.
REQ-038 LHU: funct3=101, in_alu=0x2, mem_rdata=0xBEEF0000 with mem_rvalid same cycle -> next cycle rd_data=0x0000BEEF, no WAIT_MEM.
REQ-039 x0: in_rd=0, in_we=1, in_alu=0xFFFFFFFF -> rd_we stays 0.
REQ-040 Reset in WAIT_MEM: load pending, rst=1 with mem_rvalid=1 -> no rd_we pulse, in_ready=1 after rst drops.
REQ-041 Misaligned (WB_MISALIGN_CHECK_EN): LW, in_alu=0x2 -> trap=1 one cycle, rd_we=0; macro undefined -> trap=0, write of word data.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: selects ALU/link/load result, aligns and extends load data, drives the register-file write port.
// Latency: one cycle from acceptance (or from mem_rvalid for a pending load) to the rd_we strobe.
// Backpressure: in_ready drops while a load waits for memory; optional misaligned-load trap via WB_MISALIGN_CHECK_EN.
module writeback_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        in_src,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_link,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rd_we,
    output logic [REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]   rd_data,
    output logic              trap
);

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_LOAD = 2'd1;
    localparam logic [1:0] SRC_LINK = 2'd2;
    localparam logic [1:0] SRC_RSVD = 2'd3;

    // Byte-lane index bits that exist inside one memory word (2 bits at XLEN=32, 3 at XLEN=64).
    localparam logic [2:0] LANE_MASK = 3'(XLEN / 8 - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT_MEM
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Fields of a load parked while memory has not answered yet.
    logic [REG_AW-1:0] r_ld_rd;
    logic              r_ld_we;
    logic [2:0]        r_ld_f3;
    logic [2:0]        r_ld_off;

    logic              r_rd_we;
    logic [REG_AW-1:0] r_rd_addr;
    logic [XLEN-1:0]   r_rd_data;

    logic [2:0]        w_f3;
    logic [2:0]        w_off;
    logic [2:0]        w_size_m1;
    logic [2:0]        w_lane;
    logic [XLEN-1:0]   w_shifted;
    logic [63:0]       w_sh64;
    logic [63:0]       w_ext64;
    logic              w_f3_legal;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_trap_req;

    logic              w_done;
    logic              w_we;
    logic [REG_AW-1:0] w_addr;
    logic [XLEN-1:0]   w_data;
    logic              w_latch;

    assign in_ready = (r_state == S_IDLE);
    assign rd_we    = r_rd_we;
    assign rd_addr  = r_rd_addr;
    assign rd_data  = r_rd_data;

    // Load data path: pick size/offset from the live bus in IDLE or the parked load otherwise, then align and extend.
    always_comb begin
        w_f3  = (r_state == S_IDLE) ? in_funct3 : r_ld_f3;
        w_off = (r_state == S_IDLE) ? in_alu[2:0] : r_ld_off;

        case (w_f3[1:0])
            2'b00:   w_size_m1 = 3'd0;
            2'b01:   w_size_m1 = 3'd1;
            2'b10:   w_size_m1 = 3'd3;
            default: w_size_m1 = 3'd7;
        endcase

        // Offset is rounded down to the access size and wrapped into the word, so misaligned loads never straddle.
        w_lane    = w_off & ~w_size_m1 & LANE_MASK;
        w_shifted = mem_rdata >> {w_lane, 3'b000};
        w_sh64    = 64'(w_shifted);

        case (w_f3)
            3'b011, 3'b110: w_f3_legal = (XLEN == 64);
            3'b111:         w_f3_legal = 1'b0;
            default:        w_f3_legal = 1'b1;
        endcase

        case (w_f3)
            3'b000:  w_ext64 = {{56{w_sh64[7]}},  w_sh64[7:0]};
            3'b001:  w_ext64 = {{48{w_sh64[15]}}, w_sh64[15:0]};
            3'b010:  w_ext64 = {{32{w_sh64[31]}}, w_sh64[31:0]};
            3'b011:  w_ext64 = w_sh64;
            3'b100:  w_ext64 = {56'd0, w_sh64[7:0]};
            3'b101:  w_ext64 = {48'd0, w_sh64[15:0]};
            3'b110:  w_ext64 = {32'd0, w_sh64[31:0]};
            default: w_ext64 = 64'd0;
        endcase

        if (!w_f3_legal) begin
            w_ext64 = 64'd0;
        end

        w_ld_data = w_ext64[XLEN-1:0];
    end

`ifdef WB_MISALIGN_CHECK_EN
    logic w_misalign;
    logic r_trap;

    // A legal load whose address bits below the access size are non-zero is misaligned.
    assign w_misalign = w_f3_legal && ((w_off & w_size_m1) != 3'd0);
    assign w_trap_req = w_misalign;
    assign trap       = r_trap;

    // Trap strobe: one cycle after a misaligned load is presented in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= (r_state == S_IDLE) && in_valid && (in_src == SRC_LOAD) && w_misalign;
        end
    end
`else
    assign w_trap_req = 1'b0;
    assign trap       = 1'b0;
`endif

    // Next-state and completion decode.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_we        = 1'b0;
        w_addr      = r_rd_addr;
        w_data      = r_rd_data;
        w_latch     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_src != SRC_LOAD) begin
                        w_done = 1'b1;
                        w_addr = in_rd;
                        w_we   = in_we && (in_src != SRC_RSVD);
                        w_data = (in_src == SRC_LINK) ? in_link : in_alu;
                    end else if (w_trap_req) begin
                        w_done = 1'b0;
                    end else if (mem_rvalid) begin
                        // Memory already answered: finish without visiting WAIT_MEM.
                        w_done = 1'b1;
                        w_addr = in_rd;
                        w_we   = in_we;
                        w_data = w_ld_data;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_WAIT_MEM;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    w_done      = 1'b1;
                    w_addr      = r_ld_rd;
                    w_we        = r_ld_we;
                    w_data      = w_ld_data;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and parked-load fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ld_rd  <= '0;
            r_ld_we  <= 1'b0;
            r_ld_f3  <= 3'd0;
            r_ld_off <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_ld_rd  <= in_rd;
                r_ld_we  <= in_we;
                r_ld_f3  <= in_funct3;
                r_ld_off <= in_alu[2:0];
            end
        end
    end

    // Register-file write port: strobe only on completion, never to x0; address/data follow every completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_we   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_we <= w_done && w_we && (w_addr != '0);
            if (w_done) begin
                r_rd_addr <= w_addr;
                r_rd_data <= w_data;
            end
        end
    end

    logic w_unused_src;
    assign w_unused_src = (in_src == SRC_ALU);

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage (XLEN=32): directed cases followed by randomized traffic.
// Expected results come from an arithmetic load/ALU model and a tracked copy of the write port.
// Handles both builds of WB_MISALIGN_CHECK_EN.
`define CHK(tag, o, e) check(tag, 64'(o), 64'(e))

module tb_writeback_stage;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_we;
    logic [AW-1:0]   in_rd;
    logic [1:0]      in_src;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_alu;
    logic [XLEN-1:0] in_link;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            rd_we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            trap;

    int n_chk  = 0;
    int n_pass = 0;

    logic [AW-1:0]   exp_addr;
    logic [XLEN-1:0] exp_data;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(XLEN), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_we(in_we), .in_rd(in_rd), .in_src(in_src), .in_funct3(in_funct3),
        .in_alu(in_alu), .in_link(in_link), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .trap(trap)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_chk++;
            if (rd_we === 1'b1 && rd_addr === '0) begin
                $error("FAIL mon_x0 write strobe to x0");
            end else begin
                n_pass++;
            end
            n_chk++;
            if (rd_we === 1'b1 && trap === 1'b1) begin
                $error("FAIL mon_trap_we write strobe together with trap");
            end else begin
                n_pass++;
            end
        end
    end

    function automatic bit f3_legal(input logic [2:0] f3);
        return !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    // Load result from first principles: size 1/2/4 bytes, offset rounded down to size within the 4-byte word.
    function automatic logic [XLEN-1:0] ref_load(input logic [2:0] f3, input logic [XLEN-1:0] addr,
                                                 input logic [XLEN-1:0] word);
        int size, off, lane;
        logic [XLEN-1:0] v, mask;
        if (!f3_legal(f3)) return '0;
        size = 1 << f3[1:0];
        off  = int'(addr % 4);
        lane = off - (off % size);
        v    = word >> (8 * lane);
        if (size < 4) begin
            mask = (32'd1 << (8 * size)) - 32'd1;
            v    = v & mask;
            if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [XLEN-1:0] addr);
        int size;
        if (!f3_legal(f3)) return 1'b0;
        size = 1 << f3[1:0];
        return (addr % size) != 0;
    endfunction

    task automatic do_alu(input logic [1:0] src, input logic [AW-1:0] rd, input logic we,
                          input logic [XLEN-1:0] alu, input logic [XLEN-1:0] link);
        in_valid   = 1'b1;
        in_src     = src;
        in_rd      = rd;
        in_we      = we;
        in_alu     = alu;
        in_link    = link;
        in_funct3  = 3'($urandom);
        mem_rvalid = 1'b0;
        `CHK("alu_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        exp_addr = rd;
        exp_data = (src == 2'd2) ? link : alu;
        `CHK("alu_we", rd_we, (we && src != 2'd3 && rd != 0));
        `CHK("alu_addr", rd_addr, exp_addr);
        `CHK("alu_data", rd_data, exp_data);
        `CHK("alu_trap", trap, 1'b0);
    endtask

    task automatic do_load(input logic [AW-1:0] rd, input logic we, input logic [2:0] f3,
                           input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rdata, input int wt);
        bit mis;
        mis        = ref_misaligned(f3, alu);
        in_valid   = 1'b1;
        in_src     = 2'd1;
        in_rd      = rd;
        in_we      = we;
        in_funct3  = f3;
        in_alu     = alu;
        mem_rvalid = (wt == 0);
        mem_rdata  = (wt == 0) ? rdata : $urandom;
        `CHK("ld_ready_accept", in_ready, 1'b1);
        step();
        in_valid  = 1'b0;
        in_alu    = $urandom;
        in_funct3 = 3'($urandom);
        in_rd     = 5'($urandom);
`ifdef WB_MISALIGN_CHECK_EN
        if (mis) begin
            mem_rvalid = 1'b0;
            `CHK("mis_trap", trap, 1'b1);
            `CHK("mis_we", rd_we, 1'b0);
            `CHK("mis_ready", in_ready, 1'b1);
            `CHK("mis_addr", rd_addr, exp_addr);
            step();
            `CHK("mis_trap_clear", trap, 1'b0);
            return;
        end
`else
        if (mis) `CHK("mis_notrap", trap, 1'b0);
`endif
        for (int i = 1; i <= wt; i++) begin
            `CHK("ld_wait_ready", in_ready, 1'b0);
            `CHK("ld_wait_we", rd_we, 1'b0);
            if (i == wt) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            step();
        end
        mem_rvalid = 1'b0;
        exp_addr   = rd;
        exp_data   = ref_load(f3, alu, rdata);
        `CHK("ld_we", rd_we, (we && rd != 0));
        `CHK("ld_addr", rd_addr, exp_addr);
        `CHK("ld_data", rd_data, exp_data);
        `CHK("ld_trap", trap, 1'b0);
        `CHK("ld_ready_done", in_ready, 1'b1);
    endtask

    task automatic idle_cycle();
        in_valid   = 1'b0;
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        step();
        mem_rvalid = 1'b0;
        `CHK("idle_we", rd_we, 1'b0);
        `CHK("idle_addr", rd_addr, exp_addr);
        `CHK("idle_data", rd_data, exp_data);
        `CHK("idle_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [1:0] srcs [3];
        srcs = '{2'd0, 2'd2, 2'd3};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_we      = 1'b0;
        in_rd      = '0;
        in_src     = 2'd0;
        in_funct3  = 3'd0;
        in_alu     = '0;
        in_link    = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        exp_addr   = '0;
        exp_data   = '0;

        // Reset state.
        step();
        step();
        `CHK("rst_we", rd_we, 1'b0);
        `CHK("rst_addr", rd_addr, 5'd0);
        `CHK("rst_data", rd_data, 32'd0);
        `CHK("rst_trap", trap, 1'b0);
        rst = 1'b0;
        `CHK("rst_ready", in_ready, 1'b1);

        // ALU result, then confirm the strobe is a single pulse.
        do_alu(2'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0);
        idle_cycle();

        // Signed byte load answered three cycles later.
        do_load(5'd7, 1'b1, 3'b000, 32'h3, 32'h80FF_FFFF, 3);
        idle_cycle();

        // Unsigned halfword with memory answering in the accept cycle.
        do_load(5'd9, 1'b1, 3'b101, 32'h2, 32'hBEEF_0000, 0);

        // Write to x0 suppressed; link and reserved sources.
        do_alu(2'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        do_alu(2'd2, 5'd11, 1'b1, 32'h1111_1111, 32'h0000_0104);
        do_alu(2'd3, 5'd4, 1'b1, 32'h2222_2222, 32'h0);

        // Misaligned word load; illegal funct3 values.
        do_load(5'd3, 1'b1, 3'b010, 32'h2, 32'hCAFE_F00D, 0);
        do_load(5'd12, 1'b1, 3'b011, 32'h0, 32'h1234_5678, 1);
        do_load(5'd13, 1'b1, 3'b111, 32'h0, 32'h1234_5678, 0);

        // Reset abandons a pending load even with memory responding.
        in_valid   = 1'b1;
        in_src     = 2'd1;
        in_funct3  = 3'b010;
        in_alu     = 32'h0;
        in_rd      = 5'd6;
        in_we      = 1'b1;
        mem_rvalid = 1'b0;
        step();
        in_valid = 1'b0;
        `CHK("rstw_pending", in_ready, 1'b0);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        step();
        `CHK("rstw_we", rd_we, 1'b0);
        `CHK("rstw_addr", rd_addr, 5'd0);
        `CHK("rstw_data", rd_data, 32'd0);
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        exp_addr   = '0;
        exp_data   = '0;
        `CHK("rstw_ready", in_ready, 1'b1);
        step();
        `CHK("rstw_we_after", rd_we, 1'b0);

        // Reset wins over a valid ALU instruction in the same cycle.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_src   = 2'd0;
        in_rd    = 5'd5;
        in_we    = 1'b1;
        in_alu   = 32'h77;
        step();
        `CHK("rstp_we", rd_we, 1'b0);
        `CHK("rstp_addr", rd_addr, 5'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: do_alu(srcs[$urandom_range(0, 2)], 5'($urandom), 1'($urandom), $urandom, $urandom);
                1, 2: do_load(5'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
                              int'($urandom_range(0, 3)));
                default: idle_cycle();
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
